// File: rtl/fir_mac_sched.sv
// Sequences one shared FP adder over the lookback then lookahead LUT terms of each FIR output,
// one output per OSR input strobes; flags overrun (dropped trigger) and adder timeout.
module fir_mac_sched #(
  parameter int LB_GROUPS = 25,
  parameter int LA_GROUPS = 25,
  parameter int OSR       = 1,
  parameter int TIMEOUT   = 16,
  localparam int MAX_G    = (LB_GROUPS > LA_GROUPS) ? LB_GROUPS : LA_GROUPS,
  localparam int IDX_W    = (MAX_G > 1) ? $clog2(MAX_G) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             sample_valid,
  input  logic             add_done,
  input  logic             err_clr,
  output logic             acc_clr,
  output logic             add_start,
  output logic             lut_bank,
  output logic [IDX_W-1:0] lut_idx,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun,
  output logic             timeout
);

  localparam int DCNT_W = (OSR > 1) ? $clog2(OSR) : 1;
  localparam int WCNT_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t            state;
  logic [DCNT_W-1:0] decim_cnt;
  logic [WCNT_W-1:0] wait_cnt;

  logic trigger;
  logic in_flight;
  logic last_term;
  logic bank_end;
  logic wait_expired;
  logic overrun_set;
  logic timeout_set;

  assign trigger      = enable && sample_valid && (decim_cnt == DCNT_W'(OSR - 1));
  assign in_flight    = (state == ST_CLEAR) || (state == ST_ISSUE) || (state == ST_WAIT);
  assign last_term    = lut_bank && (lut_idx == IDX_W'(LA_GROUPS - 1));
  assign bank_end     = !lut_bank && (lut_idx == IDX_W'(LB_GROUPS - 1));
  assign wait_expired = (wait_cnt == WCNT_W'(TIMEOUT - 1));
  assign overrun_set  = trigger && in_flight;
  // A completion arriving on the expiry cycle still counts, so it suppresses the timeout.
  assign timeout_set  = (state == ST_WAIT) && !add_done && wait_expired;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      decim_cnt <= '0;
      wait_cnt  <= '0;
      acc_clr   <= 1'b0;
      add_start <= 1'b0;
      lut_bank  <= 1'b0;
      lut_idx   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      acc_clr   <= 1'b0;
      add_start <= 1'b0;
      out_valid <= 1'b0;

      if (!enable) begin
        decim_cnt <= '0;
      end else if (sample_valid) begin
        decim_cnt <= trigger ? '0 : decim_cnt + 1'b1;
      end

      overrun <= (overrun && !err_clr) || overrun_set;
      timeout <= (timeout && !err_clr) || timeout_set;

      unique case (state)
        ST_IDLE: begin
          if (trigger) begin
            state   <= ST_CLEAR;
            acc_clr <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ST_CLEAR: begin
          lut_bank  <= 1'b0;
          lut_idx   <= '0;
          state     <= ST_ISSUE;
          add_start <= 1'b1;
        end
        ST_ISSUE: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (add_done) begin
            if (last_term) begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
            end else begin
              if (bank_end) begin
                lut_bank <= 1'b1;
                lut_idx  <= '0;
              end else begin
                lut_idx <= lut_idx + 1'b1;
              end
              state     <= ST_ISSUE;
              add_start <= 1'b1;
            end
          end else if (wait_expired) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          // Back-to-back outputs: a trigger here restarts without passing through IDLE.
          if (trigger) begin
            state   <= ST_CLEAR;
            acc_clr <= 1'b1;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sched.sv
// Directed bench for fir_mac_sched: LB=2/LA=2 instance with OSR=1 and a second instance with OSR=4.
module tb_fir_mac_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable, sample_valid, add_done, err_clr;
  logic       acc_clr, add_start, lut_bank, out_valid, busy, overrun, timeout;
  logic [0:0] lut_idx;

  logic       en4, sv4;
  logic       acc_clr4, add_start4, lut_bank4, out_valid4, busy4, overrun4, timeout4;
  logic [0:0] lut_idx4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fir_mac_sched #(.LB_GROUPS(2), .LA_GROUPS(2), .OSR(1), .TIMEOUT(16)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .sample_valid(sample_valid),
    .add_done(add_done), .err_clr(err_clr), .acc_clr(acc_clr), .add_start(add_start),
    .lut_bank(lut_bank), .lut_idx(lut_idx), .out_valid(out_valid), .busy(busy),
    .overrun(overrun), .timeout(timeout)
  );

  fir_mac_sched #(.LB_GROUPS(2), .LA_GROUPS(2), .OSR(4), .TIMEOUT(16)) u_dut4 (
    .clk(clk), .rst(rst), .enable(en4), .sample_valid(sv4),
    .add_done(1'b0), .err_clr(1'b0), .acc_clr(acc_clr4), .add_start(add_start4),
    .lut_bank(lut_bank4), .lut_idx(lut_idx4), .out_valid(out_valid4), .busy(busy4),
    .overrun(overrun4), .timeout(timeout4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered in the acc_clr cycle; returns in the out_valid cycle with add_done already low.
  task automatic run_terms(input string tag, input bit inj_overrun);
    for (int t = 0; t < 4; t++) begin
      step();
      add_done = 1'b0;
      chk({tag, " add_start"}, add_start, 1);
      chk({tag, " bank"}, lut_bank, (t >= 2) ? 1 : 0);
      chk({tag, " idx"}, lut_idx, t % 2);
      step();
      chk({tag, " add_start_low"}, add_start, 0);
      if (inj_overrun && t == 1) sample_valid = 1'b1;
      step();
      sample_valid = 1'b0;
      if (inj_overrun && t == 1) chk({tag, " overrun_set"}, overrun, 1);
      chk({tag, " out_valid_early"}, out_valid, 0);
      add_done = 1'b1;
    end
    step();
    add_done = 1'b0;
    chk({tag, " out_valid"}, out_valid, 1);
    chk({tag, " busy_done"}, busy, 1);
  endtask

  initial begin
    rst = 1'b0; enable = 1'b1; sample_valid = 1'b0; add_done = 1'b0; err_clr = 1'b0;
    en4 = 1'b0; sv4 = 1'b0;
    step();
    step();
    chk("rst acc_clr", acc_clr, 0);
    chk("rst add_start", add_start, 0);
    chk("rst bank", lut_bank, 0);
    chk("rst idx", lut_idx, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst overrun", overrun, 0);
    chk("rst timeout", timeout, 0);
    rst = 1'b1;
    step();

    // add_done outside WAIT is ignored
    add_done = 1'b1;
    step();
    add_done = 1'b0;
    chk("stray add_done busy", busy, 0);

    // Decimation by 4 with an enable drop resetting the count
    en4 = 1'b1; sv4 = 1'b1;
    step(); chk("osr4 s1 busy", busy4, 0);
    step(); chk("osr4 s2 busy", busy4, 0); en4 = 1'b0;
    step(); chk("osr4 en0 busy", busy4, 0); en4 = 1'b1;
    step(); chk("osr4 s3 busy", busy4, 0);
    step(); chk("osr4 s4 busy", busy4, 0);
    step(); chk("osr4 s5 busy", busy4, 0);
    step(); chk("osr4 trig acc_clr", acc_clr4, 1);
    chk("osr4 trig busy", busy4, 1);
    sv4 = 1'b0;

    // Main sequence, cycle accurate
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    chk("main acc_clr", acc_clr, 1);
    chk("main busy", busy, 1);
    run_terms("main", 1'b0);
    step();
    chk("main out_valid_low", out_valid, 0);
    chk("main busy_low", busy, 0);
    chk("main overrun", overrun, 0);

    // Overrun while waiting, then clear
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    chk("ovr acc_clr", acc_clr, 1);
    run_terms("ovr", 1'b1);
    step();
    chk("ovr busy_low", busy, 0);
    chk("ovr held", overrun, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("ovr cleared", overrun, 0);

    // Trigger during DONE restarts immediately
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    chk("dtrig acc_clr1", acc_clr, 1);
    run_terms("dtrig1", 1'b0);
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    chk("dtrig acc_clr2", acc_clr, 1);
    chk("dtrig overrun", overrun, 0);
    run_terms("dtrig2", 1'b0);
    step();
    chk("dtrig busy_low", busy, 0);

    // Adder never answers: timeout 16 WAIT cycles after add_start
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    step();
    chk("tmo add_start", add_start, 1);
    for (int i = 0; i < 16; i++) begin
      step();
      chk("tmo no_out_valid", out_valid, 0);
      chk("tmo busy", busy, 1);
    end
    chk("tmo not_yet", timeout, 0);
    step();
    chk("tmo flag", timeout, 1);
    chk("tmo busy_low", busy, 0);
    chk("tmo out_valid", out_valid, 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("tmo cleared", timeout, 0);

    // add_done on the expiry cycle wins over the timeout
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    step();
    for (int i = 0; i < 16; i++) step();
    add_done = 1'b1;
    step();
    add_done = 1'b0;
    chk("race add_start", add_start, 1);
    chk("race idx", lut_idx, 1);
    chk("race timeout", timeout, 0);
    for (int i = 0; i < 18; i++) step();
    chk("race later tmo", timeout, 1);
    chk("race later busy", busy, 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;

    // Asynchronous reset mid-WAIT, then a clean full run
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    step();
    step();
    chk("arst pre busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("arst busy", busy, 0);
    chk("arst add_start", add_start, 0);
    chk("arst out_valid", out_valid, 0);
    chk("arst timeout", timeout, 0);
    step();
    rst = 1'b1;
    step();
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    chk("post acc_clr", acc_clr, 1);
    run_terms("post", 1'b0);
    step();
    chk("post busy_low", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
